// File: rtl/ram_arbiter.sv
// Round-robin arbiter between a read-only fetch port and a read/write data port,
// sequencing each access to the shared level-sensitive RAM as setup / strobe / hold.
module ram_arbiter #(
    parameter int adlines   = 16,
    parameter int datalines = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [adlines-1:0]   f_addr,
    output logic                 f_ack,
    output logic [datalines-1:0] f_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [adlines-1:0]   d_addr,
    input  logic [datalines-1:0] d_wdata,
    output logic                 d_ack,
    output logic [datalines-1:0] d_rdata,
    output logic [adlines-1:0]   ram_address,
    output logic [datalines-1:0] ram_datain,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic [datalines-1:0] ram_dataout,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_owner_d;
    logic   r_we;
    logic   r_last_d;
    logic   w_grant;
    logic   w_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Both requesting: the port that did not win last time goes next.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (f_req && d_req) begin
                    w_grant   = 1'b1;
                    w_grant_d = ~r_last_d;
                end else if (f_req || d_req) begin
                    w_grant   = 1'b1;
                    w_grant_d = d_req;
                end
                if (w_grant) begin
                    w_next = SETUP;
                end
            end
            SETUP:   w_next = STROBE;
            STROBE:  w_next = HOLD;
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Every output is a flop; strobes are one-cycle pulses set from the state
    // about to be entered, so address/datain never move while write is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_last_d    <= 1'b1;
            ram_address <= '0;
            ram_datain  <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            f_ack       <= 1'b0;
            d_ack       <= 1'b0;
            f_rdata     <= '0;
            d_rdata     <= '0;
            busy        <= 1'b0;
        end else begin
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner_d   <= w_grant_d;
                        r_we        <= w_grant_d & d_we;
                        r_last_d    <= w_grant_d;
                        ram_address <= w_grant_d ? d_addr : f_addr;
                        if (w_grant_d) begin
                            ram_datain <= d_wdata;
                        end
                    end
                end
                SETUP: begin
                    ram_write <= r_we;
                    ram_read  <= ~r_we;
                end
                STROBE: begin
                    if (!r_we) begin
                        if (r_owner_d) begin
                            d_rdata <= ram_dataout;
                        end else begin
                            f_rdata <= ram_dataout;
                        end
                    end
                    f_ack <= ~r_owner_d;
                    d_ack <= r_owner_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random two-port traffic, checked
// every cycle against a transaction-level schedule model and a shadow memory.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic [15:0] ram_address;
    logic [15:0] ram_datain;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] ram_dataout;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    ram_arbiter #(.adlines(16), .datalines(16)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_dataout(ram_dataout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // RAM stand-in: level read, write committed on the edge ending the strobe
    logic [15:0] mem [0:511];
    bit          mem_ready;
    logic        pre_we = 1'b0;
    logic [8:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'(i * 7) ^ 16'h5A5A;
            mem_ready <= 1'b1;
        end else if (ram_write) begin
            mem[ram_address[8:0]] <= ram_datain;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end
    assign ram_dataout = ram_read ? mem[ram_address[8:0]] : 16'h0000;

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Reference model: one access per 4-cycle slot, ack 3 cycles after grant
    logic [15:0] ref_mem [0:511];
    bit          ref_ready;
    bit          active, last_d, g_own_d, g_we;
    int          g_cyc, next_free, k;
    logic [15:0] g_rdata, exp_addr, exp_datain, exp_f, exp_d;
    int          ack_who[$];
    int          ack_cyc[$];

    always @(negedge clk) begin
        if (!ref_ready) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = 16'(i * 7) ^ 16'h5A5A;
            ref_ready = 1'b1;
        end
        if (pre_we) ref_mem[pre_addr] = pre_data;
        if (reset) begin
            active = 0; last_d = 1; next_free = 0;
            exp_addr = '0; exp_datain = '0; exp_f = '0; exp_d = '0;
        end else begin
            k = cyc - g_cyc;
            if (active && k == 3 && !g_we) begin
                if (g_own_d) exp_d = g_rdata;
                else         exp_f = g_rdata;
            end
            check("busy",        busy,        active && k >= 1 && k <= 3);
            check("ram_read",    ram_read,    active && k == 2 && !g_we);
            check("ram_write",   ram_write,   active && k == 2 && g_we);
            check("f_ack",       f_ack,       active && k == 3 && !g_own_d);
            check("d_ack",       d_ack,       active && k == 3 && g_own_d);
            check("ram_address", ram_address, exp_addr);
            check("ram_datain",  ram_datain,  exp_datain);
            check("f_rdata",     f_rdata,     exp_f);
            check("d_rdata",     d_rdata,     exp_d);
            check("ack_onehot",  f_ack & d_ack, 1'b0);
            check("rw_excl",     ram_read & ram_write, 1'b0);
            if (f_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
            if (d_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
            if (cyc >= next_free && (f_req || d_req)) begin
                g_own_d   = (f_req && d_req) ? !last_d : d_req;
                last_d    = g_own_d;
                g_cyc     = cyc;
                next_free = cyc + 4;
                active    = 1;
                g_we      = g_own_d && d_we;
                exp_addr  = g_own_d ? d_addr : f_addr;
                if (g_own_d) exp_datain = d_wdata;
                if (g_we) ref_mem[exp_addr[8:0]] = d_wdata;
                else      g_rdata = ref_mem[exp_addr[8:0]];
            end
        end
    end

    task automatic preload(input logic [8:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic f_access(input logic [15:0] a, input bit keep);
        int n;
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!f_ack && n < 40);
        if (!f_ack) check("f_timeout", 0, 1);
        if (!keep) begin @(posedge clk); #1; f_req = 1'b0; end
    endtask

    task automatic d_access(input bit we, input logic [15:0] a, input logic [15:0] w, input bit keep);
        int n;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_ack && n < 40);
        if (!d_ack) check("d_timeout", 0, 1);
        if (!keep) begin @(posedge clk); #1; d_req = 1'b0; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
    endtask

    function automatic int who_at(input int idx);
        return (ack_who.size() > idx) ? ack_who[idx] : 9;
    endfunction

    function automatic int cyc_at(input int idx);
        return (ack_cyc.size() > idx) ? ack_cyc[idx] : -100;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_read",  ram_read, 0);
        check("rst_write", ram_write, 0);
        check("rst_acks",  {f_ack, d_ack}, 0);
        check("rst_addr",  ram_address, 0);
        check("rst_din",   ram_datain, 0);
        check("rst_rdata", {f_rdata, d_rdata}, 0);
        @(posedge clk); #1; reset = 1'b0;

        // Fetch read, then data write/read-back
        preload(9'h010, 16'h1234);
        f_access(16'h0010, 0);
        check("f_read_1234", f_rdata, 16'h1234);
        d_access(1, 16'h0020, 16'hBEEF, 0);
        d_access(0, 16'h0020, 16'h0000, 0);
        check("d_read_beef", d_rdata, 16'hBEEF);
        check("f_rdata_kept", f_rdata, 16'h1234);

        // Simultaneous requests after reset: F first, then strict alternation
        do_reset();
        base = ack_who.size();
        fork
            begin f_access(16'h0011, 1); f_access(16'h0012, 0); end
            begin d_access(0, 16'h0021, 16'h0, 1); d_access(0, 16'h0022, 16'h0, 0); end
        join
        check("order0", who_at(base),     0);
        check("order1", who_at(base + 1), 1);
        check("order2", who_at(base + 2), 0);
        check("order3", who_at(base + 3), 1);
        check("alt_gap", cyc_at(base + 1) - cyc_at(base), 4);

        // Asynchronous reset in the middle of a write strobe
        preload(9'h030, 16'hAAAA);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!ram_write && n < 20);
        end
        check("strobe_seen", ram_write, 1);
        #2; reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #1;
        check("rst_mid_write", ram_write, 0);
        check("rst_mid_read",  ram_read, 0);
        check("rst_mid_busy",  busy, 0);
        check("rst_mid_acks",  {f_ack, d_ack}, 0);
        check("rst_mid_addr",  ram_address, 0);
        check("rst_mid_din",   ram_datain, 0);
        check("rst_mid_rdata", {f_rdata, d_rdata}, 0);
        @(posedge clk); @(posedge clk); #1; reset = 1'b0;

        // D request arriving while F is in SETUP waits for the next slot
        base = ack_who.size();
        fork
            f_access(16'h0010, 0);
            begin @(posedge clk); d_access(0, 16'h0020, 16'h0, 0); end
        join
        check("busy_req_f", who_at(base), 0);
        check("busy_req_d", who_at(base + 1), 1);
        check("busy_req_gap", cyc_at(base + 1) - cyc_at(base), 4);

        // Read data holds across writes on the other port
        preload(9'h040, 16'h7777);
        f_access(16'h0040, 0);
        for (int i = 0; i < 3; i++) d_access(1, 16'h0041 + 16'(i), 16'(16'hC000 + i), 0);
        check("f_hold_7777", f_rdata, 16'h7777);
        check("d_hold_beef", d_rdata, 16'hBEEF);

        // Random traffic on both ports
        fork
            begin : rnd_f
                bit keep;
                keep = 0;
                for (int i = 0; i < 100; i++) begin
                    if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
                    keep = ($urandom_range(0, 1) == 1) && (i < 99);
                    f_access(16'h0100 + 16'($urandom_range(0, 15)), keep);
                end
            end
            begin : rnd_d
                bit keep;
                keep = 0;
                for (int i = 0; i < 100; i++) begin
                    if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
                    keep = ($urandom_range(0, 1) == 1) && (i < 99);
                    d_access(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)),
                             16'($urandom), keep);
                end
            end
        join
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
